// File: rtl/obuf_rr_arb.sv
// Output-direction stage: five-way round-robin arbiter feeding a small output FIFO,
// with a drop mode that discards accepted flits while the downstream neighbour is gated.
module obuf_rr_arb #(
    parameter int unsigned PYLD_W = 23,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            arb_req,
    input  logic [5*PYLD_W-1:0]   payload_i,
    output logic [4:0]            arb_gnt,
    output logic                  obuf_rdy,
    input  logic                  dst_bad,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [PYLD_W-1:0]     out_payload,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned NUM_IN = 5;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]        ptr;
    logic [2:0]        gnt_idx;
    logic [3:0]        cand;
    logic              found;
    logic              xfer;
    logic              push;
    logic              drop;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [PYLD_W-1:0] mem [DEPTH];
    logic [PYLD_W-1:0] pyld_slice [NUM_IN];
    logic [PYLD_W-1:0] win_pyld;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_slice
        assign pyld_slice[k] = payload_i[k*PYLD_W +: PYLD_W];
    end

    // Cyclic search from ptr; first requester wins, independent of obuf_rdy.
    always_comb begin
        arb_gnt = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'd5) begin
                cand = cand - 4'd5;
            end
            if (!found && arb_req[cand[2:0]]) begin
                found            = 1'b1;
                gnt_idx          = cand[2:0];
                arb_gnt[cand[2:0]] = 1'b1;
            end
        end
    end

    // Readiness uses only registered occupancy and dst_bad, never the link ready.
    assign obuf_rdy    = dst_bad | (count < CNT_W'(DEPTH));
    assign xfer        = found & obuf_rdy;
    assign push        = xfer & ~dst_bad;
    assign drop        = xfer & dst_bad;
    assign out_vld     = (count != '0);
    assign pop         = out_vld & out_rdy;
    assign win_pyld    = pyld_slice[gnt_idx];
    assign out_payload = mem[rd_ptr];

    // Round-robin pointer: one past the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gnt_idx == 3'd4) ? 3'd0 : gnt_idx + 3'd1;
        end
    end

    // FIFO storage and pointers; storage cleared so the head is never X.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= win_pyld;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_W'(1);
        end else if (pop && !push) begin
            count <= count - CNT_W'(1);
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule
